// File: rtl/font_rom_arbiter_pkg.sv
// Shared constants and state encoding for the two-port font ROM burst arbiter.
package font_rom_arbiter_pkg;

    localparam int unsigned GLYPH_BITS = 3;
    localparam int unsigned ROW_BITS   = 5;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_GLYPHS = 1 << GLYPH_BITS;
    localparam int unsigned ROWS_PER_GLYPH = 1 << ROW_BITS;
    localparam int unsigned ADDR_W     = GLYPH_BITS + ROW_BITS;
    localparam int unsigned NUM_REQ    = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    // Requester slot select for the packed per-requester input buses.
    function automatic int unsigned slot_lsb(input logic id, input int unsigned width);
        return id ? width : 0;
    endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; the last-grant register favours the other side on a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_q, last_d;

    always_comb begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
        last_d = last_q;
        if (req == 2'b11) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req[1];
        end
        if (en && (req != 2'b00)) begin
            gnt    = gnt_id ? 2'b10 : 2'b01;
            last_d = gnt_id;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Arbitrates two glyph-row burst requesters onto one font ROM with a registered,
// fixed-latency response path tagged with requester id and last-beat flag.
module font_rom_arbiter #(
    parameter int unsigned GLYPH_BITS = font_rom_arbiter_pkg::GLYPH_BITS,
    parameter int unsigned ROW_BITS   = font_rom_arbiter_pkg::ROW_BITS,
    parameter int unsigned DATA_W     = font_rom_arbiter_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   req_valid,
    input  logic [2*GLYPH_BITS-1:0]      req_glyph,
    input  logic [2*ROW_BITS-1:0]        req_row,
    input  logic [2*ROW_BITS-1:0]        req_len,
    output logic [1:0]                   req_ready,
    output logic                         rsp_valid,
    output logic                         rsp_id,
    output logic                         rsp_last,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [GLYPH_BITS+ROW_BITS-1:0] rom_ad,
    output logic                         rom_ce,
    output logic                         rom_oce,
    output logic                         rom_reset,
    input  logic [DATA_W-1:0]            rom_dout
);

    import font_rom_arbiter_pkg::*;

    localparam int unsigned AW = GLYPH_BITS + ROW_BITS;

    state_e                state_q, state_d;
    logic [GLYPH_BITS-1:0] glyph_q, glyph_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [ROW_BITS-1:0]   cnt_q, cnt_d;
    logic                  id_q, id_d;
    logic [1:0]            ready_q, ready_d;

    // Read-issue stage, aligned with rom_ce/rom_ad.
    logic                  rom_ce_q, rom_ce_d;
    logic [AW-1:0]         rom_ad_q, rom_ad_d;
    logic                  rd_id_q, rd_id_d;
    logic                  rd_last_q, rd_last_d;

    // ROM-output stage, aligned with rom_dout.
    logic                  p1_valid_q, p1_id_q, p1_last_q;

    logic                  rsp_valid_q, rsp_id_q, rsp_last_q;
    logic [DATA_W-1:0]     rsp_data_q;

    logic [1:0]            gnt;
    logic                  gnt_id;
    logic                  arb_en;

    assign arb_en = (state_q == StIdle);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        state_d   = state_q;
        glyph_d   = glyph_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        ready_d   = 2'b00;
        rom_ce_d  = 1'b0;
        rom_ad_d  = rom_ad_q;
        rd_id_d   = rd_id_q;
        rd_last_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid != 2'b00) begin
                    ready_d = gnt;
                    id_d    = gnt_id;
                    glyph_d = req_glyph[slot_lsb(gnt_id, GLYPH_BITS) +: GLYPH_BITS];
                    row_d   = req_row[slot_lsb(gnt_id, ROW_BITS) +: ROW_BITS];
                    cnt_d   = req_len[slot_lsb(gnt_id, ROW_BITS) +: ROW_BITS];
                    state_d = StBurst;
                end
            end
            StBurst: begin
                rom_ce_d  = 1'b1;
                rom_ad_d  = {glyph_q, row_q};
                rd_id_d   = id_q;
                rd_last_d = (cnt_q == '0);
                // Natural ROW_BITS overflow keeps the burst inside the same glyph.
                row_d     = row_q + ROW_BITS'(1);
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - ROW_BITS'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            glyph_q   <= '0;
            row_q     <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            ready_q   <= 2'b00;
            rom_ce_q  <= 1'b0;
            rom_ad_q  <= '0;
            rd_id_q   <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            glyph_q   <= glyph_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            ready_q   <= ready_d;
            rom_ce_q  <= rom_ce_d;
            rom_ad_q  <= rom_ad_d;
            rd_id_q   <= rd_id_d;
            rd_last_q <= rd_last_d;
        end
    end

    // Response pipeline: one stage covers the ROM latency, one registers rom_dout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_valid_q  <= 1'b0;
            p1_id_q     <= 1'b0;
            p1_last_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            p1_valid_q  <= rom_ce_q;
            p1_id_q     <= rd_id_q;
            p1_last_q   <= rom_ce_q & rd_last_q;
            rsp_valid_q <= p1_valid_q;
            rsp_last_q  <= p1_valid_q & p1_last_q;
            if (p1_valid_q) begin
                rsp_id_q   <= p1_id_q;
                rsp_data_q <= rom_dout;
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_data  = rsp_data_q;
    assign rom_ce    = rom_ce_q;
    assign rom_ad    = rom_ad_q;
    assign rom_oce   = 1'b1;
    assign rom_reset = 1'b0;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed and randomized checks of font_rom_arbiter against a cycle-schedule model
// and a behavioural font ROM with a one-cycle registered read.
module tb_font_rom_arbiter;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [5:0]  req_glyph = '0;
    logic [9:0]  req_row = '0;
    logic [9:0]  req_len = '0;
    logic [1:0]  req_ready;
    logic        rsp_valid, rsp_id, rsp_last;
    logic [31:0] rsp_data;
    logic [7:0]  rom_ad;
    logic        rom_ce, rom_oce, rom_reset;
    logic [31:0] rom_dout = '0;

    font_rom_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_glyph (req_glyph),
        .req_row   (req_row),
        .req_len   (req_len),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_last  (rsp_last),
        .rsp_data  (rsp_data),
        .rom_ad    (rom_ad),
        .rom_ce    (rom_ce),
        .rom_oce   (rom_oce),
        .rom_reset (rom_reset),
        .rom_dout  (rom_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Font ROM contents: two known rows plus a deterministic fill elsewhere.
    function automatic logic [31:0] rom_val(input int a);
        logic [7:0] b;
        b = a[7:0];
        if (a == 8'h03) return 32'h07FF_F800;
        if (a == 8'h27) return 32'h007F_F000;
        return {b, ~b, b ^ 8'h3C, 8'(b * 8'd7)};
    endfunction

    always @(posedge clk) if (rom_ce) rom_dout <= rom_val(int'(rom_ad));

    // Expected per-cycle outputs, filled in ahead of time by the model.
    logic [1:0]  e_ready [MAXC];
    bit          e_ce    [MAXC];
    logic [7:0]  e_ad    [MAXC];
    bit          e_rv    [MAXC];
    bit          e_id    [MAXC];
    bit          e_last  [MAXC];
    logic [31:0] e_data  [MAXC];

    int          free_at = 0;
    int          mlast = 1;
    logic [7:0]  m_ad = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [33:0] obs_rsp[$];
    logic [7:0]  obs_ad[$];
    int          n_rdy0 = 0;
    int          n_rdy1 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            e_ready[i] = 2'b00;
            e_ce[i]    = 1'b0;
            e_ad[i]    = '0;
            e_rv[i]    = 1'b0;
            e_id[i]    = 1'b0;
            e_last[i]  = 1'b0;
            e_data[i]  = '0;
        end
    endtask

    task automatic clear_obs();
        obs_rsp.delete();
        obs_ad.delete();
        n_rdy0 = 0;
        n_rdy1 = 0;
    endtask

    task automatic check_cycle();
        int t;
        t = cyc;
        if (e_ce[t]) m_ad = e_ad[t];
        chk("req_ready", 64'(req_ready), 64'(e_ready[t]));
        chk("rom_ce", 64'(rom_ce), 64'(e_ce[t]));
        chk("rom_ad", 64'(rom_ad), 64'(m_ad));
        chk("rsp_valid", 64'(rsp_valid), 64'(e_rv[t]));
        chk("rsp_last", 64'(rsp_last), 64'(e_rv[t] & e_last[t]));
        if (e_rv[t]) begin
            chk("rsp_id", 64'(rsp_id), 64'(e_id[t]));
            chk("rsp_data", 64'(rsp_data), 64'(e_data[t]));
        end
        if (rsp_valid === 1'b1) obs_rsp.push_back({rsp_id, rsp_last, rsp_data});
        if (rom_ce === 1'b1) obs_ad.push_back(rom_ad);
        if (req_ready[0] === 1'b1) n_rdy0++;
        if (req_ready[1] === 1'b1) n_rdy1++;
    endtask

    // One cycle: check this cycle's outputs, drive inputs for the next edge, run the model.
    task automatic step(input logic [1:0] v,
                        input int g0, input int r0, input int l0,
                        input int g1, input int r1, input int l1);
        int t, w, g, r, l, a;
        @(negedge clk);
        check_cycle();
        t = cyc;
        req_valid = v;
        req_glyph = {3'(g1), 3'(g0)};
        req_row   = {5'(r1), 5'(r0)};
        req_len   = {5'(l1), 5'(l0)};
        if (reset_n && t >= free_at && v != 2'b00) begin
            if (v == 2'b11) w = 1 - mlast;
            else            w = v[1] ? 1 : 0;
            mlast = w;
            g = w ? g1 : g0;
            r = w ? r1 : r0;
            l = w ? l1 : l0;
            e_ready[t + 1] = (w == 1) ? 2'b10 : 2'b01;
            for (int k = 0; k <= l; k++) begin
                a = g * 32 + (r + k) % 32;
                e_ce[t + 2 + k]   = 1'b1;
                e_ad[t + 2 + k]   = 8'(a);
                e_rv[t + 4 + k]   = 1'b1;
                e_id[t + 4 + k]   = (w == 1);
                e_last[t + 4 + k] = (k == l);
                e_data[t + 4 + k] = rom_val(a);
            end
            free_at = t + l + 2;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_last", 64'(rsp_last), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rom_ce", 64'(rom_ce), 64'd0);
        chk("rst_rom_ad", 64'(rom_ad), 64'd0);
        clear_from(cyc);
        mlast   = 1;
        free_at = 0;
        m_ad    = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int v, l0, l1;
        clear_from(0);
        do_reset();
        chk("rom_oce_tied", 64'(rom_oce), 64'd1);
        chk("rom_reset_tied", 64'(rom_reset), 64'd0);
        idle(2);

        // Single-row burst from requester 0.
        clear_obs();
        step(2'b01, 0, 3, 0, 0, 0, 0);
        idle(8);
        chk("d1_beats", 64'(obs_rsp.size()), 64'd1);
        if (obs_rsp.size() >= 1) chk("d1_rsp", 64'(obs_rsp[0]), {30'd0, 1'b0, 1'b1, 32'h07FF_F800});
        chk("d1_ready0", 64'(n_rdy0), 64'd1);
        chk("d1_ready1", 64'(n_rdy1), 64'd0);

        // Two-row burst from requester 1.
        clear_obs();
        step(2'b10, 0, 0, 0, 1, 7, 1);
        idle(8);
        chk("d2_beats", 64'(obs_rsp.size()), 64'd2);
        chk("d2_ads", 64'(obs_ad.size()), 64'd2);
        if (obs_ad.size() >= 2) begin
            chk("d2_ad0", 64'(obs_ad[0]), 64'h27);
            chk("d2_ad1", 64'(obs_ad[1]), 64'h28);
        end
        if (obs_rsp.size() >= 2) begin
            chk("d2_rsp0", 64'(obs_rsp[0]), {30'd0, 1'b1, 1'b0, 32'h007F_F000});
            chk("d2_rsp1", 64'(obs_rsp[1]), {30'd0, 1'b1, 1'b1, rom_val(8'h28)});
        end

        // Tie straight after reset: requester 0 first, then requester 1.
        do_reset();
        clear_obs();
        step(2'b11, 2, 0, 3, 5, 10, 3);
        repeat (5) step(2'b10, 0, 0, 0, 5, 10, 3);
        idle(10);
        chk("d3_beats", 64'(obs_rsp.size()), 64'd8);
        for (int i = 0; i < obs_rsp.size() && i < 8; i++) begin
            chk("d3_id", 64'(obs_rsp[i][33]), 64'(i >= 4));
            chk("d3_last", 64'(obs_rsp[i][32]), 64'(i == 3 || i == 7));
        end

        // Row wrap inside a glyph.
        clear_obs();
        step(2'b01, 0, 30, 3, 0, 0, 0);
        idle(8);
        chk("d4_ads", 64'(obs_ad.size()), 64'd4);
        if (obs_ad.size() >= 4) begin
            chk("d4_ad0", 64'(obs_ad[0]), 64'h1E);
            chk("d4_ad1", 64'(obs_ad[1]), 64'h1F);
            chk("d4_ad2", 64'(obs_ad[2]), 64'h00);
            chk("d4_ad3", 64'(obs_ad[3]), 64'h01);
        end

        // Reset on the second read of an 8-row burst.
        step(2'b01, 4, 0, 7, 0, 0, 0);
        idle(2);
        do_reset();
        clear_obs();
        idle(12);
        chk("d5_no_rsp", 64'(obs_rsp.size()), 64'd0);

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            v  = $urandom_range(0, 3);
            l0 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
            l1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
            step(2'(v), $urandom_range(0, 7), $urandom_range(0, 31), l0,
                 $urandom_range(0, 7), $urandom_range(0, 31), l1);
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
